// File: rtl/hyst_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hyst_cmp_pkg
// Purpose  : Shared types and default parameter constants for the hysteresis
//            comparator slice (hyst_comparator, cmp_core).
// Contents : state_t      - two-state hysteresis FSM encoding (LOW, HIGH)
//            DEF_WIDTH    - default operand width
//            DEF_HYST     - default hysteresis band
//            DEF_CNT_W    - default crossing-counter width
// Revision : 1.0 - initial release
// ============================================================================
package hyst_cmp_pkg;

    localparam int DEF_WIDTH = 10;
    localparam int DEF_HYST  = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [0:0] {
        LOW  = 1'b0,
        HIGH = 1'b1
    } state_t;

endpackage : hyst_cmp_pkg
`default_nettype wire

// File: rtl/cmp_core.sv
`default_nettype none
// ============================================================================
// Module   : cmp_core
// Purpose  : Purely combinational compare datapath. Extends both operands to
//            WIDTH+2 bits (zero- or sign-extension per signed_mode_i), forms
//            the band edges b+HYST and b-HYST and produces the flags used by
//            the hysteresis FSM.
// Ports    : a_i, b_i        - operands (WIDTH bits)
//            signed_mode_i   - 1: two's complement, 0: unsigned
//            above_o         - a > b + HYST
//            below_o         - a < b - HYST
//            equal_o         - raw a == b (band and mode independent)
// Revision : 1.0 - initial release
// ============================================================================
module cmp_core
    import hyst_cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HYST  = DEF_HYST
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             signed_mode_i,
    output logic             above_o,
    output logic             below_o,
    output logic             equal_o
);

    // Two guard bits: one for the sign of an unsigned operand, one so that
    // b +/- HYST can never overflow at either extreme of the operand range.
    localparam int c_XW = WIDTH + 2;
    localparam logic signed [c_XW-1:0] c_HYST = c_XW'(HYST);

    logic signed [c_XW-1:0] w_a_x;
    logic signed [c_XW-1:0] w_b_x;
    logic signed [c_XW-1:0] w_b_hi;
    logic signed [c_XW-1:0] w_b_lo;

    always_comb begin
        if (signed_mode_i) begin
            w_a_x = {{2{a_i[WIDTH-1]}}, a_i};
            w_b_x = {{2{b_i[WIDTH-1]}}, b_i};
        end else begin
            w_a_x = {2'b00, a_i};
            w_b_x = {2'b00, b_i};
        end
        w_b_hi  = w_b_x + c_HYST;
        w_b_lo  = w_b_x - c_HYST;
        above_o = (w_a_x > w_b_hi);
        below_o = (w_a_x < w_b_lo);
        equal_o = (a_i == b_i);
    end

endmodule : cmp_core
`default_nettype wire

// File: rtl/hyst_comparator.sv
`default_nettype none
// ============================================================================
// Module   : hyst_comparator
// Purpose  : Hysteresis comparator with valid/ready handshake. Each accepted
//            sample updates a LOW/HIGH state machine (set when a > b+HYST,
//            cleared when a < b-HYST), a raw equality flag and a saturating
//            count of state transitions; results are registered and presented
//            one clock after acceptance.
// Ports    : clk, reset            - clock, asynchronous active-high reset
//            in_valid / in_ready   - input handshake
//            a, b, signed_mode     - sample (operands + compare mode)
//            out_valid / out_ready - output handshake
//            greaterthan           - filtered "a above b" flag (state == HIGH)
//            equal                 - a == b for the accepted sample
//            cross_cnt             - saturating transition count
// Revision : 1.0 - initial release
// ============================================================================
module hyst_comparator
    import hyst_cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HYST  = DEF_HYST,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             greaterthan,
    output logic             equal,
    output logic [CNT_W-1:0] cross_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             eq_q, eq_d;
    logic             ov_q, ov_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic w_above;
    logic w_below;
    logic w_equal;
    logic w_transfer;

    cmp_core #(
        .WIDTH (WIDTH),
        .HYST  (HYST)
    ) u_cmp_core (
        .a_i           (a),
        .b_i           (b),
        .signed_mode_i (signed_mode),
        .above_o       (w_above),
        .below_o       (w_below),
        .equal_o       (w_equal)
    );

    // The result register is free either when empty or when being drained
    // this cycle, so a new sample can replace it with no bubble.
    assign in_ready   = !ov_q || out_ready;
    assign w_transfer = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOW;
            eq_q    <= 1'b0;
            ov_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            eq_q    <= eq_d;
            ov_q    <= ov_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        eq_d    = eq_q;
        ov_d    = ov_q;
        cnt_d   = cnt_q;

        if (w_transfer) begin
            ov_d = 1'b1;
            eq_d = w_equal;
            case (state_q)
                LOW:     if (w_above) state_d = HIGH;
                HIGH:    if (w_below) state_d = LOW;
                default: state_d = LOW;
            endcase
            if ((state_d != state_q) && (cnt_q != c_CNT_MAX)) begin
                cnt_d = cnt_q + c_CNT_ONE;
            end
        end else if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
    end

    assign out_valid   = ov_q;
    assign greaterthan = (state_q == HIGH);
    assign equal       = eq_q;
    assign cross_cnt   = cnt_q;

endmodule : hyst_comparator
`default_nettype wire

// File: tb/tb_hyst_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_hyst_comparator
// Purpose  : Self-checking bench for hyst_comparator (WIDTH=10, HYST=4,
//            CNT_W=8): a directed vector table applied one transfer at a
//            time, plus hand-written sequences for reset, backpressure and
//            counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hyst_comparator;

    localparam int WIDTH = 10;
    localparam int HYST  = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic             greaterthan;
    logic             equal;
    logic [CNT_W-1:0] cross_cnt;

    int n_checks;
    int n_errors;

    hyst_comparator #(
        .WIDTH (WIDTH),
        .HYST  (HYST),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .greaterthan (greaterthan),
        .equal       (equal),
        .cross_cnt   (cross_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             sm;
        logic             exp_gt;
        logic             exp_eq;
        logic [CNT_W-1:0] exp_cnt;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_outs(input string name, input logic ev, input logic egt,
                              input logic eeq, input int ecnt);
        check({name, ".out_valid"},   int'(out_valid),   int'(ev));
        check({name, ".greaterthan"}, int'(greaterthan), int'(egt));
        check({name, ".equal"},       int'(equal),       int'(eeq));
        check({name, ".cross_cnt"},   int'(cross_cnt),   ecnt);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        signed_mode = 1'b0;
        out_ready   = 1'b1;

        //            name            a        b        sm    gt    eq    cnt
        vecs[0]  = '{"u_99_95",      10'd99,  10'd95,  1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{"u_100_95_set", 10'd100, 10'd95,  1'b0, 1'b1, 1'b0, 8'd1};
        vecs[2]  = '{"u_91_hold",    10'd91,  10'd95,  1'b0, 1'b1, 1'b0, 8'd1};
        vecs[3]  = '{"u_90_clear",   10'd90,  10'd95,  1'b0, 1'b0, 1'b0, 8'd2};
        vecs[4]  = '{"u_eq_95",      10'd95,  10'd95,  1'b0, 1'b0, 1'b1, 8'd2};
        vecs[5]  = '{"u_3ff_005",    10'h3FF, 10'h005, 1'b0, 1'b1, 1'b0, 8'd3};
        vecs[6]  = '{"u_eq_0_high",  10'd0,   10'd0,   1'b0, 1'b1, 1'b1, 8'd3};
        vecs[7]  = '{"u_0_100_clr",  10'd0,   10'd100, 1'b0, 1'b0, 1'b0, 8'd4};
        vecs[8]  = '{"s_3ff_005",    10'h3FF, 10'h005, 1'b1, 1'b0, 1'b0, 8'd4};
        vecs[9]  = '{"u_3ff_3fe_nw", 10'h3FF, 10'h3FE, 1'b0, 1'b0, 1'b0, 8'd4};
        vecs[10] = '{"u_3ff_000",    10'h3FF, 10'h000, 1'b0, 1'b1, 1'b0, 8'd5};
        vecs[11] = '{"u_0_1_nw",     10'd0,   10'd1,   1'b0, 1'b1, 1'b0, 8'd5};
        vecs[12] = '{"s_min_hold",   10'h200, 10'h201, 1'b1, 1'b1, 1'b0, 8'd5};
        vecs[13] = '{"s_min_clr",    10'h200, 10'h000, 1'b1, 1'b0, 1'b0, 8'd6};
        vecs[14] = '{"s_max_set",    10'h1FF, 10'h3FF, 1'b1, 1'b1, 1'b0, 8'd7};

        // ---------------- reset state ----------------
        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 0);
        check("reset.in_ready", int'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b1;             // must not be accepted while in reset
        a        = 10'd200;
        @(posedge clk);
        #1;
        check("reset.no_accept", int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset.in_ready", int'(in_ready), 1);
        check("post_reset.gt", int'(greaterthan), 0);

        // ---------------- vector table ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            a           = vecs[i].va;
            b           = vecs[i].vb;
            signed_mode = vecs[i].sm;
            in_valid    = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check_outs(vecs[i].name, 1'b1, vecs[i].exp_gt, vecs[i].exp_eq,
                       int'(vecs[i].exp_cnt));
        end
        @(posedge clk);
        #1;
        check("drain.out_valid", int'(out_valid), 0);

        // ---------------- mid-stream asynchronous reset ----------------
        @(negedge clk);
        a           = 10'd0;
        b           = 10'd100;
        signed_mode = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b1;                // between clock edges
        #1;
        check_outs("async_reset", 1'b0, 1'b0, 1'b0, 0);
        check("async_reset.in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        check("async_reset.no_accept", int'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        @(negedge clk);
        a        = 10'd50;
        b        = 10'd10;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_outs("bp_first", 1'b1, 1'b1, 1'b0, 1);
        a = 10'd0;                   // pending sample that would clear HIGH
        b = 10'd50;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_stall.in_ready", int'(in_ready), 0);
            check_outs("bp_stall", 1'b1, 1'b1, 1'b0, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_outs("bp_rel0", 1'b1, 1'b0, 1'b0, 2);
        @(negedge clk);
        a = 10'd50;
        b = 10'd10;
        @(posedge clk);
        #1;
        check_outs("bp_rel1", 1'b1, 1'b1, 1'b0, 3);
        @(negedge clk);
        a = 10'd20;
        b = 10'd20;
        @(posedge clk);
        #1;
        check_outs("bp_rel2", 1'b1, 1'b1, 1'b1, 3);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bp_drain.out_valid", int'(out_valid), 0);

        // ---------------- saturation ----------------
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 304; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                a = 10'd200;
                b = 10'd0;
            end else begin
                a = 10'd0;
                b = 10'd200;
            end
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            if (i == 253) check("sat_254", int'(cross_cnt), 254);
            if (i == 254) check("sat_255", int'(cross_cnt), 255);
            if (i == 299) begin
                check("sat_300.cnt", int'(cross_cnt), 255);
                check("sat_300.gt", int'(greaterthan), 0);
            end
        end
        in_valid = 1'b0;
        check("sat_held.cnt", int'(cross_cnt), 255);
        @(posedge clk);
        #1;
        check("sat_idle.cnt", int'(cross_cnt), 255);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hyst_comparator
`default_nettype wire

// File: doc/hyst_comparator.md
HYST_COMPARATOR -- requirements
Module: hyst_comparator

Interface
REQ-001 The block SHALL take parameter WIDTH, default 10, as the operand width in bits (minimum 2).
REQ-002 The block SHALL take parameter HYST, default 4, as the hysteresis band, an unsigned value less than 2^(WIDTH-1).
REQ-003 The block SHALL take parameter CNT_W, default 8, as the crossing-counter width.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  the a, b and signed_mode inputs carry a sample.
REQ-007 in_ready  output  1  the block accepts a sample this cycle.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled per transaction.
REQ-010 out_valid  output  1  the result registers hold an unconsumed result.
REQ-011 out_ready  input  1  the downstream consumer takes the result.
REQ-012 greaterthan  output  1  hysteresis-filtered "a above b" flag.
REQ-013 equal  output  1  raw a==b for the accepted sample.
REQ-014 cross_cnt  output  CNT_W  saturating count of greaterthan transitions.

Function
REQ-015 A transfer SHALL occur when in_valid and in_ready are both 1; in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-016 Results for an accepted sample SHALL appear on the registered outputs exactly one clock after acceptance, with out_valid=1.
REQ-017 out_valid SHALL clear on the clock where out_valid && out_ready and no new transfer occurs.
REQ-018 While out_valid=1 and out_ready=0, greaterthan, equal, cross_cnt and out_valid SHALL hold and no sample SHALL be consumed.
REQ-019 The FSM SHALL have two states, LOW and HIGH; greaterthan SHALL be 1 in HIGH and 0 in LOW.
REQ-020 LOW->HIGH SHALL occur on a transfer where a > b+HYST; HIGH->LOW SHALL occur on a transfer where a < b-HYST; all other transfers keep the state.
REQ-021 The comparisons b+HYST and b-HYST SHALL be evaluated in WIDTH+2-bit signed arithmetic with the operands zero- or sign-extended per signed_mode, so there is no wrap-around at either extreme.
REQ-022 Each state transition SHALL increment cross_cnt by 1, saturating at 2^CNT_W-1.
REQ-023 equal SHALL be independent of HYST and of the state.
REQ-024 The FSM, counter and outputs SHALL change only on a transfer, apart from the out_valid clear defined above.

Reset
REQ-025 Assertion of reset SHALL take effect immediately, mid-transaction included, and force: state=LOW, greaterthan=0, equal=0, cross_cnt=0, out_valid=0.
REQ-026 in_ready SHALL be 1 while reset is asserted and on the first clock after deassertion.
REQ-027 A sample presented during reset SHALL NOT be accepted.

Structure
REQ-028 Package hyst_cmp_pkg SHALL hold the state typedef (LOW, HIGH) and the default parameter constants.
REQ-029 Sub-module cmp_core SHALL be purely combinational: extension, band arithmetic, and the above/below/equal flags.
REQ-030 hyst_comparator SHALL contain the FSM, the handshake, the output register and the counter.

Verification (WIDTH=10, HYST=4, CNT_W=8)
REQ-031 Reset: assert reset mid-stream -> all outputs 0 asynchronously, in_ready=1.
REQ-032 Unsigned set threshold: a=99,b=95 -> greaterthan=0; then a=100,b=95 -> greaterthan=1, cross_cnt=1, one cycle after acceptance.
REQ-033 Hysteresis: from HIGH with b=95, a=91 -> greaterthan stays 1; a=90 -> greaterthan=0, cross_cnt=2; a=b=95 -> equal=1.
REQ-034 Mode: a=10'h3FF,b=10'h005 with signed_mode=0 -> HIGH; with signed_mode=1 from LOW -> stays LOW; b=10'h3FE unsigned, a=10'h3FF -> no set, as there is no wrap.
REQ-035 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, outputs stable; then release -> exactly one sample per cycle, in order.
REQ-036 Saturation: 300 alternating crossings -> cross_cnt=255 and held.
